pe_au_sched: RTL and testbench
==============================

// Module: pe_au_sched
//
// PURPOSE
// - Sequencer for one cascaded DSP48E2 arithmetic unit inside a FIOS processing element (PE).
// - Runs the multiply-accumulate pass t_j <- t_j + a_j*b_i + carry over S rows (i) x (S+1) columns (j).
// - Generates the operand read indices, OPMODE_i and CREG_en_i for the arithmetic unit, aligned to its register depth.
// - Generates write-back strobes aligned to P_o (17-bit result limb = P_o[16:0]).
//
// PARAMETERS
// - S      8  number of 17-bit words per operand; elaboration $error unless S >= DSP_REG_LEVEL.
// - ABREG  1  A/B register depth of the driven unit (0..2).
// - MREG   1  M register depth of the driven unit (0..1).
// - CREG   1  C register depth of the driven unit (0..1).
// - Derived: DSP_REG_LEVEL = 1+ABREG+MREG; CTRL_DLY = ABREG+MREG-1; IW = $clog2(S+1).
// - Elaboration $error unless ABREG+MREG >= 1.
//
// PORTS
// - clock_i      in   1   clock, rising edge.
// - reset_n_i    in   1   asynchronous reset, active-low.
// - start_i      in   1   launch one pass; sampled only in IDLE.
// - busy_o       out  1   high from first issue cycle through done cycle.
// - done_o       out  1   one-cycle pulse coincident with the last wb_valid_o.
// - a_idx_o      out  IW  word index j driving A_i (a_j); valid while issue_o is high.
// - b_idx_o      out  IW  row index i driving B_i (b_i); valid while issue_o is high.
// - issue_o      out  1   operand indices are valid this cycle.
// - t_rd_en_o    out  1   read t[t_rd_idx_o] onto C_i; issued CTRL_DLY+1-CREG cycles after the operand issue.
// - t_rd_idx_o   out  IW  t word index to read.
// - t_zero_o     out  1   row 0: C_i forced to zero instead of reading t.
// - OPMODE_o     out  9   to OPMODE_i; issued CTRL_DLY cycles after the operand issue.
// - CREG_en_o    out  1   to CREG_en_i; high in the cycle C_i is presented (tied 0 when CREG=0).
// - wb_valid_o   out  1   P_o[16:0] is t word wb_idx_o; high DSP_REG_LEVEL cycles after the operand issue.
// - wb_idx_o     out  IW  t word index being written back.
//
// BEHAVIOUR
// - Reset: FSM=IDLE; all counters 0; every output 0, except OPMODE_o=9'h000.
// - FSM:
//   - IDLE -> RUN on start_i.
//   - RUN issues S*(S+1) ops, one per cycle, no bubbles; j counts 0..S, then wraps to 0 with i+1.
//   - RUN -> DRAIN after op (i=S-1, j=S).
//   - DRAIN -> IDLE in the cycle the last wb_valid_o fires (done_o=1 that cycle).
// - Op selection per j:
//   - j=0:       MUL_C    9'h185 (P = A*B + C).
//   - 0<j<S:     MUL_C_PS 9'h1E5 (P = A*B + C + P>>17).
//   - j=S:       C_PS     9'h1E0 (P = C + P>>17); a_idx_o=S, and the A operand is ignored.
// - Delay lines (shift registers, depth set by parameters) carry OPMODE, t_rd, CREG_en and wb tags.
//   No combinational path from start_i to any output.
// - start_i while busy: ignored. start_i in the done cycle: ignored; accepted from the next cycle.
// - Row hazard: t_j of row i is written before row i+1 reads it; guaranteed by S >= DSP_REG_LEVEL.
// - Reset asserted mid-pass: immediate abort; all delay lines cleared; no wb_valid_o after reset release.
//
// CONFIGURATION
// - PE_AU_SCHED_CYCCNT_EN defined:
//   - Adds output cyc_cnt_o [31:0].
//   - Counter cleared on accept of start_i; increments every cycle while busy_o is high.
//   - Holds its value after done_o until the next start; reset value 0.
// - PE_AU_SCHED_CYCCNT_EN undefined: port and counter are absent; all other behaviour is identical.
//
// TESTING
// - Defaults with S=4 (DSP_REG_LEVEL=3). Cycle 0 = start_i accepted; issue cycles 1..20.
//   -> busy_o high cycles 1..23; 20 wb_valid_o pulses, cycles 4..23; done_o only in cycle 23.
// - Sequence check (S=4): OPMODE_o in cycles 2..6 = 185, 1E5, 1E5, 1E5, 1E0; t_zero_o high for row 0 only;
//   wb_idx_o = 0..4 repeating.
// - Hold start_i high continuously (S=4) -> exactly one pass per accept; second pass first issue in cycle 25.
// - Assert reset_n_i low at cycle 10, release at 12 -> outputs 0 from cycle 10; no wb_valid_o afterwards;
//   new start works normally.
// - ABREG=2, MREG=0, CREG=0 (S=4) -> OPMODE_o lags issue_o by 1 cycle; t_rd_en_o lags by 2;
//   CREG_en_o stays 0; wb_valid_o lags by 3.
// - PE_AU_SCHED_CYCCNT_EN defined, S=4 defaults -> cyc_cnt_o = 23 after done_o; held until the next start.

Source files
------------

// File: rtl/pe_au_sched.sv
// rtl/pe_au_sched.sv - FIOS PE DSP48E2 multiply-accumulate pass sequencer
// Optional cycle counter output: define PE_AU_SCHED_CYCCNT_EN.
module pe_au_sched #(
  parameter int S     = 8,
  parameter int ABREG = 1,
  parameter int MREG  = 1,
  parameter int CREG  = 1,
  localparam int IW   = $clog2(S + 1)
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [IW-1:0] a_idx_o,
  output logic [IW-1:0] b_idx_o,
  output logic          issue_o,
  output logic          t_rd_en_o,
  output logic [IW-1:0] t_rd_idx_o,
  output logic          t_zero_o,
  output logic [8:0]    OPMODE_o,
  output logic          CREG_en_o,
  output logic          wb_valid_o,
`ifdef PE_AU_SCHED_CYCCNT_EN
  output logic [31:0]   cyc_cnt_o,
`endif
  output logic [IW-1:0] wb_idx_o
);

  localparam int DRL      = 1 + ABREG + MREG;
  localparam int CTRL_DLY = ABREG + MREG - 1;
  localparam int T_DLY    = CTRL_DLY + 1 - CREG;

  localparam logic [IW-1:0] J_LAST = IW'(S);
  localparam logic [IW-1:0] I_LAST = IW'(S - 1);

  localparam logic [8:0] OP_MUL_C    = 9'h185;
  localparam logic [8:0] OP_MUL_C_PS = 9'h1E5;
  localparam logic [8:0] OP_C_PS     = 9'h1E0;

  if (S < DRL) begin : g_bad_s
    $error("pe_au_sched: S must be >= DSP_REG_LEVEL");
  end
  if (ABREG + MREG < 1) begin : g_bad_regs
    $error("pe_au_sched: ABREG+MREG must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  // Stage k of the tag line carries the op issued k cycles ago; stage 0 is the issue register.
  logic [DRL:0]  pv_q, pv_d;
  logic [IW-1:0] pi_q [DRL+1];
  logic [IW-1:0] pi_d [DRL+1];
  logic [IW-1:0] pj_q [DRL+1];
  logic [IW-1:0] pj_d [DRL+1];
  logic          done_w;

  assign done_w = pv_q[DRL] && (pi_q[DRL] == I_LAST) && (pj_q[DRL] == J_LAST);

  always_comb begin
    state_d  = state_q;
    pv_d     = {pv_q[DRL-1:0], 1'b0};
    pi_d[0]  = pi_q[0];
    pj_d[0]  = pj_q[0];
    for (int k = 1; k <= DRL; k++) begin
      pi_d[k] = pi_q[k-1];
      pj_d[k] = pj_q[k-1];
    end
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          pv_d[0] = 1'b1;
          pi_d[0] = '0;
          pj_d[0] = '0;
        end
      end
      RUN: begin
        if (pi_q[0] == I_LAST && pj_q[0] == J_LAST) begin
          state_d = DRAIN;
        end else begin
          pv_d[0] = 1'b1;
          if (pj_q[0] == J_LAST) begin
            pj_d[0] = '0;
            pi_d[0] = pi_q[0] + 1'b1;
          end else begin
            pj_d[0] = pj_q[0] + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (done_w) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      pv_q    <= '0;
      for (int k = 0; k <= DRL; k++) begin
        pi_q[k] <= '0;
        pj_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      pv_q    <= pv_d;
      for (int k = 0; k <= DRL; k++) begin
        pi_q[k] <= pi_d[k];
        pj_q[k] <= pj_d[k];
      end
    end
  end

`ifdef PE_AU_SCHED_CYCCNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (state_q == IDLE && start_i) cyc_cnt_d = '0;
    else if (state_q != IDLE)       cyc_cnt_d = cyc_cnt_q + 32'd1;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) cyc_cnt_q <= '0;
    else            cyc_cnt_q <= cyc_cnt_d;
  end

  assign cyc_cnt_o = cyc_cnt_q;
`endif

  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_w;
  assign issue_o = pv_q[0];
  assign a_idx_o = pv_q[0] ? pj_q[0] : '0;
  assign b_idx_o = pv_q[0] ? pi_q[0] : '0;

  always_comb begin
    OPMODE_o = 9'h000;
    if (pv_q[CTRL_DLY]) begin
      if (pj_q[CTRL_DLY] == '0)         OPMODE_o = OP_MUL_C;
      else if (pj_q[CTRL_DLY] == J_LAST) OPMODE_o = OP_C_PS;
      else                               OPMODE_o = OP_MUL_C_PS;
    end
  end

  // Row 0 accumulates onto zero, so it never reads t.
  assign t_rd_en_o  = pv_q[T_DLY] && (pi_q[T_DLY] != '0);
  assign t_zero_o   = pv_q[T_DLY] && (pi_q[T_DLY] == '0);
  assign t_rd_idx_o = t_rd_en_o ? pj_q[T_DLY] : '0;
  assign CREG_en_o  = (CREG != 0) && pv_q[T_DLY];

  assign wb_valid_o = pv_q[DRL];
  assign wb_idx_o   = pv_q[DRL] ? pj_q[DRL] : '0;

endmodule

// File: tb/tb_pe_au_sched.sv
// tb/tb_pe_au_sched.sv - randomized bench for pe_au_sched against a schedule model
module tb_pe_au_sched;
  localparam int S    = 4;
  localparam int IW   = $clog2(S + 1);
  localparam int NOPS = S * (S + 1);
  localparam int W    = 16 + 4 * IW;
  localparam int NCYC = 1500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic          busy_a, done_a, issue_a, trd_a, tz_a, creg_a, wbv_a;
  logic [IW-1:0] aidx_a, bidx_a, tidx_a, wbidx_a;
  logic [8:0]    op_a;
  logic          busy_b, done_b, issue_b, trd_b, tz_b, creg_b, wbv_b;
  logic [IW-1:0] aidx_b, bidx_b, tidx_b, wbidx_b;
  logic [8:0]    op_b;
`ifdef PE_AU_SCHED_CYCCNT_EN
  logic [31:0]   cnt_a, cnt_b;
`endif

  pe_au_sched #(.S(S), .ABREG(1), .MREG(1), .CREG(1)) dut_a (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start),
    .busy_o(busy_a), .done_o(done_a), .a_idx_o(aidx_a), .b_idx_o(bidx_a),
    .issue_o(issue_a), .t_rd_en_o(trd_a), .t_rd_idx_o(tidx_a), .t_zero_o(tz_a),
    .OPMODE_o(op_a), .CREG_en_o(creg_a), .wb_valid_o(wbv_a),
`ifdef PE_AU_SCHED_CYCCNT_EN
    .cyc_cnt_o(cnt_a),
`endif
    .wb_idx_o(wbidx_a)
  );

  pe_au_sched #(.S(S), .ABREG(2), .MREG(0), .CREG(0)) dut_b (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start),
    .busy_o(busy_b), .done_o(done_b), .a_idx_o(aidx_b), .b_idx_o(bidx_b),
    .issue_o(issue_b), .t_rd_en_o(trd_b), .t_rd_idx_o(tidx_b), .t_zero_o(tz_b),
    .OPMODE_o(op_b), .CREG_en_o(creg_b), .wb_valid_o(wbv_b),
`ifdef PE_AU_SCHED_CYCCNT_EN
    .cyc_cnt_o(cnt_b),
`endif
    .wb_idx_o(wbidx_b)
  );

  always #5 clk = ~clk;

  int cyc;
  int vec;
  int mis;
  bit has_pass;
  int c0;
  int prev_cnt;

  // Pass launched in cycle c0: op n (row n/(S+1), column n%(S+1)) issues in cycle c0+1+n.
  function automatic logic [W-1:0] model(int c, int cd, int cr, int drl);
    logic busy, done, iss, opv, tv, trd, tz, crg, wbv;
    logic [IW-1:0] ai, bi, tidx, wbi;
    logic [8:0] op;
    int n, total, j;
    busy = 0; done = 0; iss = 0; trd = 0; tz = 0; crg = 0; wbv = 0;
    ai = '0; bi = '0; tidx = '0; wbi = '0; op = 9'h000;
    if (has_pass) begin
      total = NOPS + drl;
      busy = (c >= c0 + 1) && (c <= c0 + total);
      done = (c == c0 + total);
      n = c - c0 - 1;
      iss = (n >= 0) && (n < NOPS);
      if (iss) begin
        ai = IW'(n % (S + 1));
        bi = IW'(n / (S + 1));
      end
      n = c - c0 - 1 - cd;
      opv = (n >= 0) && (n < NOPS);
      if (opv) begin
        j = n % (S + 1);
        op = (j == 0) ? 9'h185 : (j == S) ? 9'h1E0 : 9'h1E5;
      end
      n = c - c0 - 1 - (cd + 1 - cr);
      tv = (n >= 0) && (n < NOPS);
      if (tv) begin
        trd = (n / (S + 1)) != 0;
        tz  = (n / (S + 1)) == 0;
        if (trd) tidx = IW'(n % (S + 1));
        crg = (cr != 0);
      end
      n = c - c0 - 1 - drl;
      wbv = (n >= 0) && (n < NOPS);
      if (wbv) wbi = IW'(n % (S + 1));
    end
    return {busy, done, ai, bi, iss, trd, tidx, tz, op, crg, wbv, wbi};
  endfunction

  function automatic int exp_cnt(int c, int drl);
    int v;
    if (!has_pass || c <= c0) return prev_cnt;
    v = c - c0 - 1;
    if (v > NOPS + drl) v = NOPS + drl;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    check("dut_a", 64'({busy_a, done_a, aidx_a, bidx_a, issue_a, trd_a, tidx_a, tz_a,
                        op_a, creg_a, wbv_a, wbidx_a}), 64'(model(cyc, 1, 1, 3)));
    check("dut_b", 64'({busy_b, done_b, aidx_b, bidx_b, issue_b, trd_b, tidx_b, tz_b,
                        op_b, creg_b, wbv_b, wbidx_b}), 64'(model(cyc, 1, 0, 3)));
`ifdef PE_AU_SCHED_CYCCNT_EN
    check("cnt_a", 64'(cnt_a), 64'(exp_cnt(cyc, 3)));
    check("cnt_b", 64'(cnt_b), 64'(exp_cnt(cyc, 3)));
`endif
  endtask

  logic [8:0] op_seq [5];

  task automatic pin_literals();
    if (cyc >= 2 && cyc <= 6) check("op_seq_a", 64'(op_a), 64'(op_seq[cyc-2]));
    if (cyc >= 4 && cyc <= 8) check("wb_idx_a", 64'(wbidx_a), 64'(cyc - 4));
    if (cyc == 1)  check("busy_first", 64'(busy_a), 64'd1);
    if (cyc == 3)  check("wb_early", 64'(wbv_a), 64'd0);
    if (cyc == 4)  check("wb_first", 64'(wbv_a), 64'd1);
    if (cyc == 22) check("done_early", 64'(done_a), 64'd0);
    if (cyc == 23) check("done_a", 64'(done_a), 64'd1);
    if (cyc == 24) check("busy_after", 64'(busy_a), 64'd0);
    if (cyc == 25) check("issue_pass2", 64'(issue_a), 64'd1);
    if (cyc == 2)  check("op_b_lag", 64'(op_b), 64'h185);
    if (cyc == 2)  check("tz_b_early", 64'(tz_b), 64'd0);
    if (cyc == 3)  check("tz_b_lag", 64'(tz_b), 64'd1);
    if (cyc == 8)  check("trd_b_row1", 64'(trd_b), 64'd1);
    if (cyc == 95) check("wb_after_rst", 64'(wbv_a), 64'd0);
    if (cyc == 101) check("issue_after_rst", 64'(issue_a), 64'd1);
`ifdef PE_AU_SCHED_CYCCNT_EN
    if (cyc == 24) check("cnt_done", 64'(cnt_a), 64'd23);
    if (cyc == 48) check("cnt_hold", 64'(cnt_a), 64'd23);
`endif
  endtask

  initial begin
    vec = 0; mis = 0; has_pass = 0; c0 = 0; prev_cnt = 0; cyc = -3;
    op_seq[0] = 9'h185; op_seq[1] = 9'h1E5; op_seq[2] = 9'h1E5;
    op_seq[3] = 9'h1E5; op_seq[4] = 9'h1E0;
    repeat (3) @(negedge clk);
    compare_all();
    check("reset_opmode", 64'(op_a), 64'h0);
    rst_n = 1'b1;
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      compare_all();
      pin_literals();
      if (cyc < 60)        start = 1'b1;
      else if (cyc == 80)  start = 1'b1;
      else if (cyc == 90)  begin start = 1'b0; rst_n = 1'b0; end
      else if (cyc == 92)  rst_n = 1'b1;
      else if (cyc == 100) start = 1'b1;
      else if (cyc >= 130) begin
        if (!rst_n) rst_n = 1'b1;
        else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
        start = ($urandom_range(0, 3) == 0);
      end else start = 1'b0;
      if (!rst_n) begin
        has_pass = 0;
        prev_cnt = 0;
        #1;
        compare_all();
      end else if (start && (!has_pass || cyc > c0 + NOPS + 3)) begin
        prev_cnt = exp_cnt(cyc, 3);
        c0 = cyc;
        has_pass = 1;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
